iq_sample_packer: RTL and testbench

//  Parametrised AXI-Stream IQ compressor/packer: quantises each sc16 sample (16b I + 16b Q) to BITS-bit I/Q fields,

---
 rtl/iq_packer_pkg.sv | 40 ++++
 rtl/iq_field_quant.sv | 44 ++++
 rtl/iq_sample_packer.sv | 147 ++++++++++++++
 tb/tb_iq_sample_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iq_packer_pkg
//  Description : Shared constants and helpers for the IQ sample packer:
//                lane/count sizing, FSM state encodings, saturation limits.
//                Saturation is only used when PACKER_SAT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package iq_packer_pkg;

  // FSM state encodings
  localparam logic [0:0] c_ST_IDLE = 1'b0;  // no packet open
  localparam logic [0:0] c_ST_FILL = 1'b1;  // packet open, lanes being filled

  // Number of sc16 samples packed per output word
  function automatic int calc_lanes(input int bits, input int out_width);
    return out_width / (2 * bits);
  endfunction

  // Width of the valid-lane count (must hold 0..LANES)
  function automatic int calc_count_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Largest positive two's-complement value of a bits-wide field
  function automatic logic [7:0] sat_max(input int bits);
    return 8'((1 << (bits - 1)) - 1);
  endfunction

  // Most negative two's-complement value of a bits-wide field
  function automatic logic [7:0] sat_min(input int bits);
    return 8'(1 << (bits - 1));
  endfunction

  // Sizing for the default configuration (BITS=4, OUT_WIDTH=32)
  localparam int c_DEF_LANES   = calc_lanes(4, 32);
  localparam int c_DEF_COUNT_W = calc_count_w(c_DEF_LANES);

endpackage : iq_packer_pkg
`default_nettype wire

// File: rtl/iq_field_quant.sv
`default_nettype none
// ============================================================================
//  Module      : iq_field_quant
//  Description : Quantises one 16-bit two's-complement component to a
//                BITS-wide field taken at bit index 'shift'. With
//                PACKER_SAT_EN defined, out-of-range values saturate to
//                the field's max/min; otherwise the field wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module iq_field_quant
  import iq_packer_pkg::*;
#(
  parameter int BITS    = 4,
  parameter int SHIFT_W = 4
) (
  input  logic [15:0]        comp,
  input  logic [SHIFT_W-1:0] shift,
  output logic [BITS-1:0]    field
);

  logic [BITS-1:0] w_plain;

  // Plain bit-select of comp[shift+BITS-1 : shift]
  assign w_plain = BITS'(comp >> shift);

`ifdef PACKER_SAT_EN
  localparam logic [7:0] c_MAX = sat_max(BITS);
  localparam logic [7:0] c_MIN = sat_min(BITS);

  logic [15:0] w_head;
  logic        w_ovf;

  // Arithmetic shift leaves only comp[15 : shift+BITS-1] sign-extended;
  // the field is representable only if those bits are all equal.
  assign w_head = 16'($signed(comp) >>> (32'(shift) + 32'(BITS - 1)));
  assign w_ovf  = ~((w_head == 16'h0000) | (w_head == 16'hFFFF));
  assign field  = w_ovf ? (comp[15] ? c_MIN[BITS-1:0] : c_MAX[BITS-1:0])
                        : w_plain;
`else
  assign field = w_plain;
`endif

endmodule : iq_field_quant
`default_nettype wire

// File: rtl/iq_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : iq_sample_packer
//  Description : AXI-Stream IQ compressor/packer. Quantises each sc16
//                sample to BITS-bit I/Q fields and packs LANES samples per
//                OUT_WIDTH word (lane 0 in the LSBs). A beat with i_tlast
//                flushes the partial word with unused lanes zeroed.
//                Optional macro PACKER_SAT_EN enables field saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module iq_sample_packer
  import iq_packer_pkg::*;
#(
  parameter int BITS      = 4,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT_W   = 4,
  parameter int LANES     = calc_lanes(BITS, OUT_WIDTH),
  parameter int COUNT_W   = calc_count_w(LANES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic [31:0]          i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [COUNT_W-1:0]   o_count
);

  localparam int c_LANE_W    = 2 * BITS;
  localparam int c_MAX_SHIFT = 16 - BITS;

  logic [0:0]           r_state;
  logic [SHIFT_W-1:0]   r_shift_q;
  logic [COUNT_W-1:0]   r_lane;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_o_tdata;
  logic                 r_o_tlast;
  logic                 r_o_tvalid;
  logic [COUNT_W-1:0]   r_o_count;

  logic [SHIFT_W-1:0]   w_cfg_clamped;
  logic [SHIFT_W-1:0]   w_shift_eff;
  logic [BITS-1:0]      w_field_i;
  logic [BITS-1:0]      w_field_q;
  logic [c_LANE_W-1:0]  w_lane;
  logic [OUT_WIDTH-1:0] w_acc_next;
  logic                 w_accept;
  logic                 w_last_lane;
  logic                 w_complete;

  // Output register can take a new word whenever it is empty or draining
  assign i_tready = ~r_o_tvalid | o_tready;
  assign w_accept = i_tvalid & i_tready;

  // Shift values beyond the top of the component are pinned to the top field
  assign w_cfg_clamped = (32'(cfg_shift) > 32'(c_MAX_SHIFT))
                       ? SHIFT_W'(c_MAX_SHIFT) : cfg_shift;

  // The first beat of a packet already uses the shift it latches
  assign w_shift_eff = (r_state == c_ST_IDLE) ? w_cfg_clamped : r_shift_q;

  iq_field_quant #(
    .BITS    (BITS),
    .SHIFT_W (SHIFT_W)
  ) u_quant_i (
    .comp  (i_tdata[31:16]),
    .shift (w_shift_eff),
    .field (w_field_i)
  );

  iq_field_quant #(
    .BITS    (BITS),
    .SHIFT_W (SHIFT_W)
  ) u_quant_q (
    .comp  (i_tdata[15:0]),
    .shift (w_shift_eff),
    .field (w_field_q)
  );

  assign w_lane      = {w_field_i, w_field_q};
  assign w_last_lane = (r_lane == COUNT_W'(LANES - 1));
  assign w_complete  = w_accept & (w_last_lane | i_tlast);

  // Accumulator with the current beat dropped into its lane
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == COUNT_W'(k)) begin
        w_acc_next[k*c_LANE_W +: c_LANE_W] = w_lane;
      end
    end
  end

  // Lane counter, accumulator and output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lane     <= '0;
      r_acc      <= '0;
      r_o_tdata  <= '0;
      r_o_tlast  <= 1'b0;
      r_o_tvalid <= 1'b0;
      r_o_count  <= '0;
    end else begin
      if (r_o_tvalid & o_tready) begin
        r_o_tvalid <= 1'b0;
      end
      if (w_accept) begin
        if (w_complete) begin
          r_o_tdata  <= w_acc_next;
          r_o_tlast  <= i_tlast;
          r_o_count  <= r_lane + COUNT_W'(1);
          r_o_tvalid <= 1'b1;
          r_lane     <= '0;
          r_acc      <= '0;
        end else begin
          r_acc  <= w_acc_next;
          r_lane <= r_lane + COUNT_W'(1);
        end
      end
    end
  end

  // Packet FSM; shift is captured once per packet on its first beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= c_ST_IDLE;
      r_shift_q <= '0;
    end else if (w_accept) begin
      if (r_state == c_ST_IDLE) begin
        r_shift_q <= w_cfg_clamped;
      end
      r_state <= i_tlast ? c_ST_IDLE : c_ST_FILL;
    end
  end

  assign o_tdata  = r_o_tdata;
  assign o_tlast  = r_o_tlast;
  assign o_tvalid = r_o_tvalid;
  assign o_count  = r_o_count;

endmodule : iq_sample_packer
`default_nettype wire

// File: tb/tb_iq_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_sample_packer
//  Description : Directed self-checking bench for iq_sample_packer
//                (BITS=4, OUT_WIDTH=32, LANES=4). Define PACKER_SAT_EN
//                consistently with the DUT build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iq_sample_packer;

  logic        clk;
  logic        reset_n;
  logic [3:0]  cfg_shift;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [2:0]  o_count;

  int vectors;
  int miscompares;

`ifdef PACKER_SAT_EN
  localparam logic [31:0] c_EXP_SAT_A = 32'h0000_0078;
  localparam logic [31:0] c_EXP_SAT_B = 32'h0000_0078;
`else
  localparam logic [31:0] c_EXP_SAT_A = 32'h0000_0070;
  localparam logic [31:0] c_EXP_SAT_B = 32'h0000_0000;
`endif

  iq_sample_packer #(
    .BITS      (4),
    .OUT_WIDTH (32),
    .SHIFT_W   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_shift (cfg_shift),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .o_count   (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [31:0] c,
                          input logic [31:0] l);
    chk({tag, "_valid"}, 32'(o_tvalid), 32'd1);
    chk({tag, "_data"},  o_tdata, d);
    chk({tag, "_count"}, 32'(o_count), c);
    chk({tag, "_last"},  32'(o_tlast), l);
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input logic last);
    int   n;
    logic rdy;
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    n = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      rdy = i_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    chk("send_accept", 32'(rdy), 32'd1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] beat_d[$];
  logic        beat_l[$];
  logic [31:0] exp_d[$];
  int          exp_c[$];
  logic        exp_l[$];

  initial begin
    int          lens[10];
    logic [31:0] acc;
    logic [31:0] d;
    int          lane;

    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    cfg_shift   = 4'd12;
    i_tdata     = '0;
    i_tlast     = 1'b0;
    i_tvalid    = 1'b0;
    o_tready    = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast",  32'(o_tlast),  32'd0);
    chk("rst_tdata",  o_tdata,       32'd0);
    chk("rst_count",  32'(o_count),  32'd0);
    chk("rst_tready", 32'(i_tready), 32'd1);
    reset_n = 1'b1;
    idle(1);

    // Full four-sample packet
    send(32'h1000_2000, 1'b0);
    send(32'h3000_4000, 1'b0);
    send(32'h5000_6000, 1'b0);
    chk("t1_no_early", 32'(o_tvalid), 32'd0);
    send(32'h7000_8000, 1'b1);
    chk_word("t1", 32'h7856_3412, 32'd4, 32'd1);
    idle(1);
    chk("t1_fall", 32'(o_tvalid), 32'd0);

    // Short packet flush, then single-sample packet restarts at lane 0
    send(32'h1000_2000, 1'b0);
    send(32'h3000_4000, 1'b1);
    chk_word("t2", 32'h0000_3412, 32'd2, 32'd1);
    send(32'h5000_6000, 1'b1);
    chk_word("t2_single", 32'h0000_0056, 32'd1, 32'd1);
    idle(1);

    // Overflow behaviour at shift 8
    cfg_shift = 4'd8;
    send(32'h0700_F000, 1'b1);
    chk_word("t3_a", c_EXP_SAT_A, 32'd1, 32'd1);
    send(32'h1000_F000, 1'b1);
    chk_word("t3_b", c_EXP_SAT_B, 32'd1, 32'd1);

    // Out-of-range shift clamps to 12
    cfg_shift = 4'd15;
    send(32'h1000_2000, 1'b1);
    chk_word("clamp", 32'h0000_0012, 32'd1, 32'd1);

    // Shift change mid-packet is ignored until the next packet
    cfg_shift = 4'd12;
    send(32'h1000_2000, 1'b0);
    cfg_shift = 4'd8;
    send(32'h3000_4000, 1'b1);
    chk_word("midcfg", 32'h0000_3412, 32'd2, 32'd1);
    cfg_shift = 4'd12;

    // Back-to-back single-sample packets keep o_tvalid high
    send(32'h1000_2000, 1'b1);
    chk_word("b2b_0", 32'h0000_0012, 32'd1, 32'd1);
    send(32'h3000_4000, 1'b1);
    chk_word("b2b_1", 32'h0000_0034, 32'd1, 32'd1);
    idle(1);

    // Backpressure: 8-sample packet, output stalled for 5 cycles
    o_tready = 1'b0;
    send(32'h1000_2000, 1'b0);
    send(32'h3000_4000, 1'b0);
    send(32'h5000_6000, 1'b0);
    send(32'h7000_8000, 1'b0);
    chk_word("t4_w0", 32'h7856_3412, 32'd4, 32'd0);
    i_tdata  = 32'h9000_A000;
    i_tvalid = 1'b1;
    repeat (5) begin
      chk("t4_hold_ready", 32'(i_tready), 32'd0);
      chk("t4_hold_valid", 32'(o_tvalid), 32'd1);
      chk("t4_hold_data",  o_tdata, 32'h7856_3412);
      @(posedge clk);
      #1;
    end
    o_tready = 1'b1;
    send(32'h9000_A000, 1'b0);
    chk("t4_drain", 32'(o_tvalid), 32'd0);
    send(32'hB000_C000, 1'b0);
    send(32'hD000_E000, 1'b0);
    send(32'hF000_0000, 1'b1);
    chk_word("t4_w1", 32'hF0DE_BC9A, 32'd4, 32'd1);
    idle(1);
    chk("t4_no_extra", 32'(o_tvalid), 32'd0);

    // Reset mid-word discards the partial word
    send(32'h1000_2000, 1'b0);
    send(32'h3000_4000, 1'b0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk("t5_rst_valid", 32'(o_tvalid), 32'd0);
    send(32'h5000_6000, 1'b0);
    send(32'h7000_8000, 1'b0);
    send(32'h9000_A000, 1'b0);
    chk("t5_no_early", 32'(o_tvalid), 32'd0);
    send(32'hB000_C000, 1'b1);
    chk_word("t5", 32'hBC9A_7856, 32'd4, 32'd1);
    idle(1);

    // Mixed lengths with random valid gaps and ready stalls
    lens = '{1, 2, 3, 4, 5, 7, 8, 9, 12, 37};
    foreach (lens[p]) begin
      lane = 0;
      acc  = '0;
      for (int b = 0; b < lens[p]; b++) begin
        d = $urandom;
        beat_d.push_back(d);
        beat_l.push_back(b == lens[p] - 1);
        acc[lane*8 +: 8] = {d[31:28], d[15:12]};
        lane++;
        if (lane == 4 || b == lens[p] - 1) begin
          exp_d.push_back(acc);
          exp_c.push_back(lane);
          exp_l.push_back(b == lens[p] - 1);
          acc  = '0;
          lane = 0;
        end
      end
    end

    fork
      begin
        for (int i = 0; i < beat_d.size(); i++) begin
          if ($urandom_range(0, 2) == 0) idle(1);
          send(beat_d[i], beat_l[i]);
        end
        i_tvalid = 1'b0;
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < exp_d.size() && cyc < 5000) begin
          @(posedge clk);
          #1;
          o_tready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (o_tvalid && o_tready) begin
            chk("rnd_data",  o_tdata, exp_d[got]);
            chk("rnd_count", 32'(o_count), 32'(exp_c[got]));
            chk("rnd_last",  32'(o_tlast), 32'(exp_l[got]));
            got++;
          end
          cyc++;
        end
        chk("rnd_words", 32'(got), 32'(exp_d.size()));
      end
    join

    o_tready = 1'b1;
    idle(2);
    chk("rnd_no_extra", 32'(o_tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_iq_sample_packer
`default_nettype wire
